// File: rtl/uart_tx_interface.sv
// uart_tx_interface: host-side transmit FIFO feeding a UART transmitter with a start/done handshake
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   wr_uart, w_data     : host write strobe and data (dropped while tx_full)
//   tx_full, tx_empty   : registered FIFO status
//   tx_busy             : FSM not idle
//   tx_start, tx_data   : one-cycle start pulse and held byte for the transmitter
//   tx_done_tick        : transmitter finished the current byte
//   UART_TX_OVERRUN_FLAG_EN adds clr_overrun / overrun (sticky write-while-full flag)
module uart_tx_interface #(
   parameter int N = 8,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_uart,
   input  logic [N-1:0] w_data,
   output logic         tx_full,
   output logic         tx_empty,
   output logic         tx_busy,
   output logic         tx_start,
   output logic [N-1:0] tx_data,
   input  logic         tx_done_tick
`ifdef UART_TX_OVERRUN_FLAG_EN
   ,
   input  logic         clr_overrun,
   output logic         overrun
`endif
);
   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
   state_t state, state_next;
   logic [N-1:0] mem [2**W];
   logic [W-1:0] wptr, rptr;
   logic full, empty, wr_en, rd_en;
   assign wr_en = wr_uart & ~full;
   assign rd_en = (state == IDLE) & ~empty;
   assign tx_full = full;
   assign tx_empty = empty;
   assign tx_busy = state != IDLE;
   assign tx_start = state == START;
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
         full <= 1'b0;
         empty <= 1'b1;
         tx_data <= '0;
         state <= IDLE;
      end else begin
         state <= state_next;
         if (wr_en) mem[wptr] <= w_data;
         if (wr_en) wptr <= wptr + 1'b1;
         if (rd_en) rptr <= rptr + 1'b1;
         if (rd_en) tx_data <= mem[rptr];
         // a simultaneous write and pop leaves occupancy, and so both flags, unchanged
         if (wr_en & ~rd_en) begin
            empty <= 1'b0;
            full <= (wptr + 1'b1) == rptr;
         end else if (rd_en & ~wr_en) begin
            full <= 1'b0;
            empty <= (rptr + 1'b1) == wptr;
         end
      end
   end
   always_comb begin
      state_next = state;
      if (state == IDLE && !empty) state_next = START;
      else if (state == START) state_next = WAIT;
      else if (state == WAIT && tx_done_tick) state_next = IDLE;
   end
`ifdef UART_TX_OVERRUN_FLAG_EN
   always_ff @(posedge clk) begin
      if (reset) overrun <= 1'b0;
      else if (wr_uart & full) overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
   end
`endif
endmodule

// File: tb/tb_uart_tx_interface.sv
// tb_uart_tx_interface: directed bench with a queue-based reference model for uart_tx_interface
module tb_uart_tx_interface;
   logic clk = 0, reset = 1, wr_uart = 0, done_man = 0, done_auto = 0, auto_en = 0;
   logic [7:0] w_data = 0;
   logic tx_full, tx_empty, tx_busy, tx_start, tx_done_tick;
   logic [7:0] tx_data;
`ifdef UART_TX_OVERRUN_FLAG_EN
   logic clr_overrun = 0, overrun;
`endif
   int compared = 0, mismatched = 0, cyc_n = 0, last_done = 0, cnt = 0;
   logic chk_on = 0;
   logic [7:0] starts[$];
   int gaps[$];
   logic [7:0] mq[$];
   int ph = -1;
   logic [7:0] md = 0;
   logic mov = 0;
   assign tx_done_tick = done_man | done_auto;
   always #5 clk = ~clk;
   uart_tx_interface #(.N(8), .W(2)) dut (
      .clk(clk), .reset(reset), .wr_uart(wr_uart), .w_data(w_data),
      .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy),
      .tx_start(tx_start), .tx_data(tx_data), .tx_done_tick(tx_done_tick)
`ifdef UART_TX_OVERRUN_FLAG_EN
      , .clr_overrun(clr_overrun), .overrun(overrun)
`endif
   );
   task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
      compared++;
      if (a !== e) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at cycle %0d", n, a, e, cyc_n);
      end
   endtask
   // reference model: queue of waiting bytes, byte in flight, and phase of the handshake
   // (-1 nothing in flight, 0 start cycle, 1 awaiting done)
   always @(posedge clk) begin
      cyc_n++;
      if (reset) begin
         mq.delete();
         ph = -1;
         md = 0;
         mov = 0;
      end else begin
`ifdef UART_TX_OVERRUN_FLAG_EN
         if (wr_uart && mq.size() == 4) mov = 1;
         else if (clr_overrun) mov = 0;
`endif
         if (ph == -1 && mq.size() > 0) begin
            md = mq.pop_front();
            ph = 0;
            if (wr_uart) mq.push_back(w_data);
         end else begin
            if (wr_uart && mq.size() < 4) mq.push_back(w_data);
            if (ph == 0) ph = 1;
            else if (ph == 1 && tx_done_tick) ph = -1;
         end
      end
   end
   always @(negedge clk) begin
      if (chk_on) begin
         cmp("tx_start", tx_start, ph == 0);
         cmp("tx_busy", tx_busy, ph != -1);
         cmp("tx_empty", tx_empty, mq.size() == 0);
         cmp("tx_full", tx_full, mq.size() == 4);
         cmp("tx_data", tx_data, md);
`ifdef UART_TX_OVERRUN_FLAG_EN
         cmp("overrun", overrun, mov);
`endif
         if (tx_start) begin
            starts.push_back(tx_data);
            gaps.push_back(cyc_n - last_done);
         end
         if (tx_done_tick) last_done = cyc_n;
      end
   end
   // transmitter stand-in: done tick about 10 cycles after each start
   always @(posedge clk) begin
      #1;
      done_auto = 0;
      if (!auto_en) cnt = 0;
      else begin
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) done_auto = 1;
         end
         if (tx_start) cnt = 10;
      end
   end
   task automatic cyc(input logic w, input logic [7:0] d, input logic dn);
      wr_uart = w;
      w_data = d;
      done_man = dn;
      @(posedge clk);
      #1;
      wr_uart = 0;
      done_man = 0;
   endtask
   task automatic do_reset();
      reset = 1;
      cyc(0, 0, 0);
      reset = 0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
   initial begin
      int base, t;
      logic [7:0] exp_seq[$];
      do_reset();
      do_reset();
      chk_on = 1;
      cmp("rst_empty", tx_empty, 1);
      cmp("rst_full", tx_full, 0);
      cmp("rst_busy", tx_busy, 0);
      cmp("rst_data", tx_data, 0);
      // single write
      cyc(1, 8'hA5, 0);
      cmp("single_nostart_E0", tx_start, 0);
      cmp("single_notempty", tx_empty, 0);
      cyc(0, 0, 0);
      cmp("single_start", tx_start, 1);
      cmp("single_data", tx_data, 8'hA5);
      cmp("single_empty_after_pop", tx_empty, 1);
      cyc(0, 0, 0);
      cmp("single_start_one_cycle", tx_start, 0);
      repeat (3) cyc(0, 0, 0);
      cmp("single_busy_wait", tx_busy, 1);
      cyc(0, 0, 1);
      cmp("single_idle_after_done", tx_busy, 0);
      // burst with automatic done ticks
      auto_en = 1;
      base = starts.size();
      for (int i = 1; i <= 6; i++) begin
         cyc(1, 8'(i), 0);
         if (i >= 5) cmp("burst_full", tx_full, 1);
         if (i == 4) cmp("burst_not_full_yet", tx_full, 0);
      end
      t = 0;
      while (starts.size() < base + 5 && t < 1000) begin
         cyc(0, 0, 0);
         t++;
      end
      cmp("burst_starts_seen", starts.size() >= base + 5, 1);
      t = 0;
      while (tx_busy && t < 100) begin
         cyc(0, 0, 0);
         t++;
      end
      repeat (20) cyc(0, 0, 0);
      cmp("burst_total_starts", starts.size(), base + 5);
      for (int i = 0; i < 5 && base + i < starts.size(); i++) begin
         cmp("burst_order", starts[base+i], 8'(i + 1));
         if (i > 0) cmp("burst_gap", gaps[base+i], 2);
      end
      auto_en = 0;
      cyc(0, 0, 0);
      // simultaneous write and pop at occupancy 2, across pointer wrap
      base = starts.size();
      cyc(1, 8'h10, 0);
      cyc(1, 8'h11, 0);
      cyc(1, 8'h12, 0);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 1);
         cyc(1, 8'h13 + 8'(i), 0);
         cmp("simul_data", tx_data, 8'h11 + 8'(i));
         cmp("simul_not_full", tx_full, 0);
         cmp("simul_not_empty", tx_empty, 0);
         cyc(0, 0, 0);
      end
      for (int i = 0; i < 2; i++) begin
         cyc(0, 0, 1);
         repeat (3) cyc(0, 0, 0);
      end
      cyc(0, 0, 1);
      cmp("simul_drained", tx_empty, 1);
      for (int i = 0; i <= 10; i++) exp_seq.push_back(8'h10 + 8'(i));
      cmp("simul_count", starts.size() - base, 11);
      for (int i = 0; i < 11 && base + i < starts.size(); i++) cmp("simul_order", starts[base+i], exp_seq[i]);
      // spurious done ticks in IDLE and START
      cyc(0, 0, 1);
      cmp("spur_idle_busy", tx_busy, 0);
      cmp("spur_idle_empty", tx_empty, 1);
      cyc(1, 8'h3C, 0);
      cyc(0, 0, 0);
      cmp("spur_start", tx_start, 1);
      cyc(0, 0, 1);
      cmp("spur_start_ignored", tx_busy, 1);
      cyc(0, 0, 0);
      cmp("spur_still_busy", tx_busy, 1);
      cyc(0, 0, 1);
      cmp("spur_done_idle", tx_busy, 0);
      // reset in WAIT with 3 queued
      for (int i = 0; i < 4; i++) cyc(1, 8'h70 + 8'(i), 0);
      cmp("rstwait_busy_before", tx_busy, 1);
      reset = 1;
      cyc(0, 0, 0);
      reset = 0;
      cmp("rstwait_busy", tx_busy, 0);
      cmp("rstwait_empty", tx_empty, 1);
      cmp("rstwait_start", tx_start, 0);
      cmp("rstwait_data", tx_data, 0);
      base = starts.size();
      repeat (6) cyc(0, 0, 0);
      cmp("rstwait_no_start", starts.size(), base);
`ifdef UART_TX_OVERRUN_FLAG_EN
      for (int i = 0; i < 5; i++) cyc(1, 8'h80 + 8'(i), 0);
      cmp("ovr_full", tx_full, 1);
      cmp("ovr_clear_initially", overrun, 0);
      cyc(1, 8'h99, 0);
      cmp("ovr_set", overrun, 1);
      cyc(0, 0, 0);
      cmp("ovr_hold", overrun, 1);
      clr_overrun = 1;
      cyc(1, 8'h9A, 0);
      clr_overrun = 0;
      cmp("ovr_set_wins", overrun, 1);
      clr_overrun = 1;
      cyc(0, 0, 0);
      clr_overrun = 0;
      cmp("ovr_cleared", overrun, 0);
      do_reset();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
